// File: rtl/leon_mem_pkg.sv
// Shared types and constants for the LEON memory responders (dcache and icache side).
package leon_mem_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_ILL  = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    RESP = 2'b10
  } state_e;

  localparam logic [31:0] NOP_INST = 32'h0100_0000;

endpackage

// File: rtl/leon_dmem_responder_if.sv
// Core <-> data-memory request/response bundle; hold and mds are active-low.
interface leon_dmem_responder_if;

  logic        req_valid;
  logic [31:0] req_addr;
  logic        req_write;
  logic [1:0]  req_size;
  logic [31:0] req_wdata;

  logic [31:0] rsp_data;
  logic        rsp_hold;
  logic        rsp_mds;
  logic        rsp_mexc;
  logic        rsp_werr;

  modport master (
    output req_valid, req_addr, req_write, req_size, req_wdata,
    input  rsp_data, rsp_hold, rsp_mds, rsp_mexc, rsp_werr
  );

  modport slave (
    input  req_valid, req_addr, req_write, req_size, req_wdata,
    output rsp_data, rsp_hold, rsp_mds, rsp_mexc, rsp_werr
  );

endinterface

// File: rtl/leon_mem_lane_merge.sv
// Big-endian store merge: lane 3 (bits 31:24) is the lowest byte address.
module leon_mem_lane_merge
  import leon_mem_pkg::*;
(
  input  logic [31:0] old_word,
  input  logic [31:0] wdata,
  input  size_e       size,
  input  logic [1:0]  addr_lo,
  output logic [31:0] merged
);

  always_comb begin
    merged = old_word;
    case (size)
      SZ_BYTE: begin
        case (addr_lo)
          2'd0:    merged[31:24] = wdata[7:0];
          2'd1:    merged[23:16] = wdata[7:0];
          2'd2:    merged[15:8]  = wdata[7:0];
          default: merged[7:0]   = wdata[7:0];
        endcase
      end
      SZ_HALF: begin
        if (addr_lo[1]) merged[15:0]  = wdata[15:0];
        else            merged[31:16] = wdata[15:0];
      end
      SZ_WORD: merged = wdata;
      default: merged = old_word;
    endcase
  end

endmodule

// File: rtl/leon_dmem_responder.sv
// Data-memory responder for the LEON dcache port: wait states, error checks, backdoor preload.
module leon_dmem_responder
  import leon_mem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_STATES = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h4000_0000,
  parameter int unsigned WP_WORDS    = 16,
  localparam int unsigned AW         = $clog2(DEPTH_WORDS)
) (
  input  logic                  clk,
  input  logic                  rst,
  leon_dmem_responder_if.slave  bus,
  input  logic                  bd_we,
  input  logic [AW-1:0]         bd_addr,
  input  logic [31:0]           bd_wdata
);

  state_e      state;
  logic [3:0]  wait_cnt;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        write_q;
  size_e       size_q;
  logic [31:0] data_q;

  logic [31:0] mem [DEPTH_WORDS];

  logic [AW-1:0] idx;
  logic          in_window;
  logic          misaligned;
  logic          mexc;
  logic          werr;
  logic [31:0]   old_word;
  logic [31:0]   merged_word;
  logic [31:0]   resp_word;

  // BASE_ADDR is aligned to the window size, so a window hit is a compare of the upper bits.
  assign idx       = addr_q[AW+1:2];
  assign in_window = (addr_q[31:AW+2] == BASE_ADDR[31:AW+2]);

  always_comb begin
    misaligned = 1'b0;
    case (size_q)
      SZ_BYTE: misaligned = 1'b0;
      SZ_HALF: misaligned = addr_q[0];
      SZ_WORD: misaligned = (addr_q[1:0] != 2'b00);
      default: misaligned = 1'b1;
    endcase
  end

  assign mexc     = !in_window || misaligned;
  assign werr     = !mexc && write_q && (32'(idx) < WP_WORDS);
  assign old_word = mem[idx];

  leon_mem_lane_merge u_merge (
    .old_word (old_word),
    .wdata    (wdata_q),
    .size     (size_q),
    .addr_lo  (addr_q[1:0]),
    .merged   (merged_word)
  );

  assign resp_word = (mexc || werr) ? 32'h0 : (write_q ? merged_word : old_word);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      wait_cnt <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      write_q  <= 1'b0;
      size_q   <= SZ_BYTE;
      data_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            addr_q  <= bus.req_addr;
            wdata_q <= bus.req_wdata;
            write_q <= bus.req_write;
            size_q  <= size_e'(bus.req_size);
            if (WAIT_STATES > 0) begin
              state    <= WAIT;
              wait_cnt <= 4'(WAIT_STATES - 1);
            end else begin
              state <= RESP;
            end
          end
        end
        WAIT: begin
          if (wait_cnt == 4'd0) state <= RESP;
          else                  wait_cnt <= wait_cnt - 4'd1;
        end
        RESP: begin
          data_q <= resp_word;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Core store is written after the backdoor so it wins a same-word collision.
  always_ff @(posedge clk) begin
    if (bd_we) mem[bd_addr] <= bd_wdata;
    if (state == RESP && write_q && !mexc && !werr) mem[idx] <= merged_word;
  end

  assign bus.rsp_hold = (state != WAIT);
  assign bus.rsp_mds  = (state != RESP);
  assign bus.rsp_mexc = (state == RESP) && mexc;
  assign bus.rsp_werr = (state == RESP) && werr;
  assign bus.rsp_data = (state == RESP) ? resp_word : data_q;

endmodule

// File: doc/leon_dmem_responder.md
Name: leon_dmem_responder

Overview:
- Synthesizable data-memory responder for the LEON integer unit's data-cache port; it replaces the bench-driven cache stub on the dcache side.
- Accepts load/store requests from the core and drives the response signals: data, hold (stall), mds (data strobe), mexc and werr.
- Inserts a configurable number of wait states.
- Includes a backdoor preload port so benches can initialise memory without core traffic.

Parameters:
- DEPTH_WORDS, 1024: memory depth in 32-bit words; must be a power of 2.
- WAIT_STATES, 2: stall cycles inserted before each response; range 0..15.
- BASE_ADDR, 32'h4000_0000: byte address of word 0; must be aligned to DEPTH_WORDS*4.
- WP_WORDS, 16: the lowest WP_WORDS words are write-protected.

Ports:
- clk  in  1  core clock; all state changes on its rising edge.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  1  core requests an access this cycle.
- req_addr  in  32  byte address, big-endian (SPARC).
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  00 = byte, 01 = half, 10 = word, 11 = illegal.
- req_wdata  in  32  store data, right-justified.
- rsp_data  out  32  full aligned load word; the core does lane extraction.
- rsp_hold  out  1  active-low: 0 stalls the core pipeline.
- rsp_mds  out  1  active-low strobe: 0 marks the cycle in which rsp_data/errors are valid.
- rsp_mexc  out  1  memory exception (out of window or misaligned); valid with mds=0.
- rsp_werr  out  1  write error (protected region); valid with mds=0.
- bd_we  in  1  backdoor write enable.
- bd_addr  in  $clog2(DEPTH_WORDS)  backdoor word index.
- bd_wdata  in  32  backdoor write word.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, wait counter=0.
  - rsp_hold=1, rsp_mds=1, rsp_mexc=0, rsp_werr=0, rsp_data=0.
  - Memory contents are not cleared.
  - Reset mid-access aborts the access; a pending store is discarded.
- States are IDLE, WAIT and RESP.
- IDLE:
  - On req_valid=1 at edge N, latch addr/write/size/wdata.
  - If WAIT_STATES>0, go to WAIT: rsp_hold=0 for cycles N+1..N+WAIT_STATES.
  - If WAIT_STATES=0, go directly to RESP.
- WAIT: counter decrements each cycle; at 0 go to RESP. req_valid is ignored.
- RESP (cycle N+WAIT_STATES+1):
  - rsp_hold=1, rsp_mds=0 for exactly one cycle, then return to IDLE.
  - req_valid is ignored in RESP; the next request is accepted in IDLE, giving minimum spacing of WAIT_STATES+2 cycles.
- Error checks, evaluated in priority order:
  - mexc: address outside [BASE_ADDR, BASE_ADDR+4*DEPTH_WORDS), OR size=11, OR half with addr[0]=1, OR word with addr[1:0]≠0.
  - werr: store to word index < WP_WORDS (only if no mexc).
  - A faulting access leaves memory unmodified and drives rsp_data=0.
- Loads: rsp_data = mem[idx], where idx = (addr-BASE_ADDR)>>2.
- Stores (byte lanes, big-endian):
  - byte: wdata[7:0] written to lane 3-addr[1:0]; lane 3 = bits 31:24.
  - half: wdata[15:0] written to bits 31:16 if addr[1]=0, else bits 15:0.
  - word: all 32 bits written.
  - Store responses drive rsp_data = merged word written.
- Outside RESP: rsp_mds=1, rsp_mexc=0, rsp_werr=0, and rsp_data holds its last value.
- Backdoor write is accepted in any state, one cycle later. If it hits the same word in the same cycle as a core store commit, the core store wins.
- A read in RESP of a word backdoor-written that same cycle returns the old value.

Decomposition:
- Shared package leon_mem_pkg:
  - size_e (SZ_BYTE, SZ_HALF, SZ_WORD, SZ_ILL).
  - state_e (IDLE, WAIT, RESP).
  - NOP_INST = 32'h0100_0000 constant for benches.
- One sub-module, leon_mem_lane_merge: combinational old-word/wdata/size/addr[1:0] → merged word. It is reused by the icache responder.

Test Plan:
- Reset, backdoor preload mem[20]=32'hDEAD_BEEF, load word at BASE+0x50 (WAIT_STATES=2) → hold=0 for 2 cycles, then mds=0 with rsp_data=DEADBEEF, mexc=0, werr=0.
- Byte stores of 0x11, 0x22, 0x33, 0x44 to BASE+0x60..0x63, then load word → 32'h1122_3344.
- Half store 0xABCD at BASE+0x62 over 32'h1122_3344 → reload gives 32'h1122_ABCD. Half store at BASE+0x61 → mexc=1, memory unchanged.
- Word store to BASE+0x04 (protected) → werr=1, mexc=0, reload returns the preloaded value. Load at BASE-4 → mexc=1, rsp_data=0.
- Assert rst=0 during WAIT of a store to BASE+0x80 → outputs return to reset values immediately and mem[32] is unchanged. After release, a new request is served normally.
- WAIT_STATES=0 build: back-to-back requests each respond in the cycle after acceptance with hold never 0. req_valid during RESP is ignored.
